// File: rtl/sprite_line_scheduler.sv
// Per-scanline visible-sprite list builder and draw-command sequencer (ping-pong list banks).
// Optional build macro SPRITE_SCHED_REVERSE_EN drains each list from last entry to first.
`timescale 1ns/1ps
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES  = 512,
  parameter int unsigned MAX_PER_LINE = 64,
  parameter int unsigned Y_W          = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           line,
  input  logic [Y_W-1:0] line_y,
  output logic           attr_rd,
  output logic [8:0]     attr_addr,
  input  logic [Y_W-1:0] attr_y,
  input  logic [7:0]     attr_h,
  input  logic [11:0]    attr_x,
  input  logic [7:0]     attr_w,
  output logic           spr_valid,
  input  logic           spr_ready,
  output logic [8:0]     spr_index,
  output logic [7:0]     spr_row,
  output logic [11:0]    spr_lb_addr,
  output logic [7:0]     spr_width,
  output logic           spr_done,
  output logic           overflow,
  output logic           scan_late
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = $clog2(MAX_PER_LINE + 1);
  localparam int unsigned PTR_W  = $clog2(MAX_PER_LINE);

  typedef struct packed {
    logic [8:0]  index;
    logic [7:0]  row;
    logic [11:0] x;
    logic [7:0]  w;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EMIT, D_DONE} drain_state_t;

  scan_state_t  scan_state;
  drain_state_t drain_state;

  entry_t             list_mem [2*MAX_PER_LINE];
  entry_t             spr_q;
  logic               fill_bank;
  logic [CNT_W-1:0]   fill_cnt;
  logic [CNT_W-1:0]   drain_left;
  logic [PTR_W-1:0]   drain_ptr;
  logic [Y_W-1:0]     line_y_q;
  logic               chk_vld;
  logic [ADDR_W-1:0]  chk_addr;
  logic               ovf_scan;

  logic [Y_W-1:0]     diff_c;
  logic               visible_c;
  logic               list_full_c;
  logic               wr_en_c;
  logic [PTR_W-1:0]   ptr_first_c;
  logic [PTR_W-1:0]   ptr_nxt_c;
  logic [PTR_W-1:0]   rd_ptr_c;
  entry_t             wr_entry_c;

  // Visibility compare on the attribute word returned for chk_addr
  always_comb begin
    diff_c      = line_y_q - attr_y;
    visible_c   = chk_vld && (attr_h != 8'd0) && (diff_c < Y_W'(attr_h));
    list_full_c = (fill_cnt == CNT_W'(MAX_PER_LINE));
    wr_en_c     = (scan_state == S_SCAN) && visible_c && !list_full_c && !line;
    wr_entry_c  = '{index: chk_addr, row: diff_c[7:0], x: attr_x, w: attr_w};
`ifdef SPRITE_SCHED_REVERSE_EN
    ptr_first_c = PTR_W'(fill_cnt - CNT_W'(1));
    ptr_nxt_c   = drain_ptr - PTR_W'(1);
`else
    ptr_first_c = '0;
    ptr_nxt_c   = drain_ptr + PTR_W'(1);
`endif
    // First fetch reads the current pointer; later fetches read ahead
    rd_ptr_c    = spr_valid ? ptr_nxt_c : drain_ptr;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) list_mem[{fill_bank, fill_cnt[PTR_W-1:0]}] <= wr_entry_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_state  <= S_IDLE;
      drain_state <= D_IDLE;
      attr_rd     <= 1'b0;
      attr_addr   <= '0;
      spr_valid   <= 1'b0;
      spr_q       <= '0;
      spr_done    <= 1'b1;
      overflow    <= 1'b0;
      scan_late   <= 1'b0;
      fill_bank   <= 1'b0;
      fill_cnt    <= '0;
      drain_left  <= '0;
      drain_ptr   <= '0;
      line_y_q    <= '0;
      chk_vld     <= 1'b0;
      chk_addr    <= '0;
      ovf_scan    <= 1'b0;
    end else if (line) begin
      // Line pulse: swap banks, publish last scan status, restart both FSMs
      line_y_q    <= line_y;
      fill_bank   <= ~fill_bank;
      fill_cnt    <= '0;
      scan_state  <= S_SCAN;
      attr_rd     <= 1'b1;
      attr_addr   <= '0;
      chk_vld     <= 1'b0;
      ovf_scan    <= 1'b0;
      overflow    <= ovf_scan;
      scan_late   <= (scan_state == S_SCAN);
      drain_left  <= fill_cnt;
      drain_ptr   <= ptr_first_c;
      spr_valid   <= 1'b0;
      if (fill_cnt == '0) begin
        spr_done    <= 1'b1;
        drain_state <= D_DONE;
      end else begin
        spr_done    <= 1'b0;
        drain_state <= D_EMIT;
      end
    end else begin
      case (scan_state)
        S_SCAN: begin
          chk_vld  <= attr_rd;
          chk_addr <= attr_addr;
          if (attr_rd) begin
            if (attr_addr == ADDR_W'(NUM_SPRITES - 1)) attr_rd <= 1'b0;
            else attr_addr <= attr_addr + ADDR_W'(1);
          end
          if (chk_vld && chk_addr == ADDR_W'(NUM_SPRITES - 1)) scan_state <= S_DONE;
          if (visible_c) begin
            if (list_full_c) begin
              ovf_scan   <= 1'b1;
              scan_state <= S_DONE;
              attr_rd    <= 1'b0;
              chk_vld    <= 1'b0;
            end else begin
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
        end
        default: chk_vld <= 1'b0;
      endcase

      case (drain_state)
        D_EMIT: begin
          if (!spr_valid) begin
            spr_valid <= 1'b1;
            spr_q     <= list_mem[{~fill_bank, rd_ptr_c}];
          end else if (spr_ready) begin
            if (drain_left == CNT_W'(1)) begin
              spr_valid   <= 1'b0;
              spr_done    <= 1'b1;
              drain_state <= D_DONE;
            end else begin
              drain_left <= drain_left - CNT_W'(1);
              drain_ptr  <= ptr_nxt_c;
              spr_q      <= list_mem[{~fill_bank, rd_ptr_c}];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign spr_index   = spr_q.index;
  assign spr_row     = spr_q.row;
  assign spr_lb_addr = spr_q.x;
  assign spr_width   = spr_q.w;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized bench for sprite_line_scheduler against a list-level reference model.
`timescale 1ns/1ps
module tb_sprite_line_scheduler;

  localparam int unsigned NS = 512;
  localparam int unsigned MP = 64;

  typedef logic [36:0] ent_t;  // {index,row,x,w}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line = 1'b0;
  logic [9:0]  line_y = '0;
  logic        attr_rd;
  logic [8:0]  attr_addr;
  logic [9:0]  attr_y = '0;
  logic [7:0]  attr_h = '0;
  logic [11:0] attr_x = '0;
  logic [7:0]  attr_w = '0;
  logic        spr_valid;
  logic        spr_ready = 1'b1;
  logic [8:0]  spr_index;
  logic [7:0]  spr_row;
  logic [11:0] spr_lb_addr;
  logic [7:0]  spr_width;
  logic        spr_done;
  logic        overflow;
  logic        scan_late;
  ent_t        payload;

  sprite_line_scheduler dut (
    .clk(clk), .rst_n(rst_n), .line(line), .line_y(line_y),
    .attr_rd(attr_rd), .attr_addr(attr_addr), .attr_y(attr_y), .attr_h(attr_h),
    .attr_x(attr_x), .attr_w(attr_w), .spr_valid(spr_valid), .spr_ready(spr_ready),
    .spr_index(spr_index), .spr_row(spr_row), .spr_lb_addr(spr_lb_addr),
    .spr_width(spr_width), .spr_done(spr_done), .overflow(overflow), .scan_late(scan_late)
  );

  assign payload = {spr_index, spr_row, spr_lb_addr, spr_width};

  initial forever #5 clk = ~clk;

  // Attribute table with one-cycle read latency
  logic [9:0]  t_y [NS];
  logic [7:0]  t_h [NS];
  logic [11:0] t_x [NS];
  logic [7:0]  t_w [NS];

  always @(posedge clk) begin
    if (attr_rd) begin
      attr_y <= t_y[attr_addr];
      attr_h <= t_h[attr_addr];
      attr_x <= t_x[attr_addr];
      attr_w <= t_w[attr_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  ent_t scan_q[$];
  ent_t drain_q[$];
  ent_t got_q[$];
  bit   scan_ovf = 1'b0;
  bit   scan_late_m = 1'b0;
  int   ready_mode = 0;
  int   hs_cnt = 0;
  int   stall_cnt = 0;
  bit   mon_en = 1'b0;

  // Expected list of a scan given how many cycles it ran before the next line
  function automatic void model_scan(input logic [9:0] y, input int gap);
    int   k;
    logic [9:0] d;
    ent_t tmp[$];
    k = gap - 2;
    if (k > int'(NS)) k = NS;
    scan_q.delete();
    scan_ovf = 1'b0;
    scan_late_m = 1'b0;
    for (int i = 0; i < k; i++) begin
      d = y - t_y[i];
      if (t_h[i] != 8'd0 && int'(d) < int'(t_h[i])) begin
        if (scan_q.size() == int'(MP)) begin
          scan_ovf = 1'b1;
          break;
        end
        scan_q.push_back({9'(i), d[7:0], t_x[i], t_w[i]});
      end
    end
    if (!scan_ovf) scan_late_m = (gap - 2 < int'(NS));
`ifdef SPRITE_SCHED_REVERSE_EN
    tmp = scan_q;
    scan_q.delete();
    foreach (tmp[j]) scan_q.push_front(tmp[j]);
`endif
  endfunction

  // Consumer: pick ready for the coming edge, record transfers, check stall stability
  initial begin
    bit   prev_stall = 1'b0;
    ent_t prev_payload = '0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: spr_ready = 1'b1;
        1: spr_ready = ($urandom_range(3) != 0);
        2: begin
          if (spr_valid && hs_cnt == 1 && stall_cnt < 5) begin
            spr_ready = 1'b0;
            stall_cnt++;
          end else spr_ready = 1'b1;
        end
        default: spr_ready = 1'b0;
      endcase
      if (mon_en) begin
        if (prev_stall) begin
          check("hold_valid", 64'(spr_valid), 64'd1);
          check("hold_payload", 64'(payload), 64'(prev_payload));
        end
        if (spr_valid && spr_ready) begin
          got_q.push_back(payload);
          hs_cnt++;
        end
        prev_stall = spr_valid && !spr_ready;
        prev_payload = payload;
      end else prev_stall = 1'b0;
    end
  end

  task automatic check_drain();
    check("done_before_line", 64'(spr_done), 64'd1);
    check("drain_count", 64'(got_q.size()), 64'(drain_q.size()));
    for (int i = 0; i < drain_q.size() && i < got_q.size(); i++)
      check($sformatf("cmd%0d", i), 64'(got_q[i]), 64'(drain_q[i]));
  endtask

  // One line pulse followed by gap-1 further cycles before the next one
  task automatic do_line(input logic [9:0] y, input int gap);
    check_drain();
    line = 1'b1;
    line_y = y;
    @(negedge clk);
    line = 1'b0;
    check("valid_L1", 64'(spr_valid), 64'd0);
    check("attr_rd_L1", 64'(attr_rd), 64'd1);
    check("attr_addr_L1", 64'(attr_addr), 64'd0);
    check("overflow", 64'(overflow), 64'(scan_ovf));
    check("scan_late", 64'(scan_late), 64'(scan_late_m));
    check("done_L1", 64'(spr_done), 64'(scan_q.size() == 0));
    drain_q = scan_q;
    got_q.delete();
    hs_cnt = 0;
    stall_cnt = 0;
    model_scan(y, gap);
    @(negedge clk);
    check("valid_L2", 64'(spr_valid), 64'(drain_q.size() != 0));
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic clear_table();
    for (int i = 0; i < int'(NS); i++) begin
      t_y[i] = 10'($urandom);
      t_h[i] = 8'd0;
      t_x[i] = 12'($urandom);
      t_w[i] = 8'($urandom);
    end
  endtask

  task automatic rand_table(input logic [9:0] y, input int near_pct);
    for (int i = 0; i < int'(NS); i++) begin
      t_x[i] = 12'($urandom);
      t_w[i] = 8'($urandom);
      t_h[i] = 8'($urandom_range(0, 24));
      if ($urandom_range(99) < near_pct) t_y[i] = y - 10'($urandom_range(0, 30));
      else t_y[i] = 10'($urandom);
    end
  endtask

  initial begin
    logic [9:0] y;
    int gap;
    clear_table();
    repeat (3) @(negedge clk);
    check("rst_attr_rd", 64'(attr_rd), 64'd0);
    check("rst_attr_addr", 64'(attr_addr), 64'd0);
    check("rst_valid", 64'(spr_valid), 64'd0);
    check("rst_payload", 64'(payload), 64'd0);
    check("rst_done", 64'(spr_done), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_scan_late", 64'(scan_late), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Two overlapping sprites on line 16
    clear_table();
    t_y[3] = 10'd10; t_h[3] = 8'd8;
    t_y[7] = 10'd15; t_h[7] = 8'd4;
    do_line(10'd16, 600);

    // Y wraparound, plus a zero-height sprite at the same Y
    clear_table();
    t_y[5] = 10'd1020; t_h[5] = 8'd8;
    t_y[6] = 10'd1020; t_h[6] = 8'd0;
    do_line(10'd2, 600);

    // 70 visible sprites overflow a 64-entry list
    clear_table();
    for (int i = 0; i < 70; i++) begin
      t_y[i] = 10'd0; t_h[i] = 8'd255;
    end
    do_line(10'd5, 600);

    // Small list; the overflow list drains under random ready meanwhile
    clear_table();
    for (int i = 0; i < 5; i++) begin
      t_y[i*40] = 10'd98; t_h[i*40] = 8'd4;
    end
    ready_mode = 1;
    do_line(10'd100, 600);

    // Stall the second command of the small list for five cycles
    y = 10'($urandom);
    rand_table(y, 10);
    ready_mode = 2;
    do_line(y, 600);

    // Random tables, full scans with random ready, or short gaps with ready held high
    for (int n = 0; n < 8; n++) begin
      y = 10'($urandom);
      rand_table(y, $urandom_range(2, 25));
      if ($urandom_range(1) == 0) begin
        ready_mode = 1;
        gap = 600;
      end else begin
        ready_mode = 0;
        gap = $urandom_range(80, 600);
      end
      do_line(y, gap);
    end

    // Line 100 cycles into a scan
    ready_mode = 0;
    y = 10'($urandom);
    rand_table(y, 20);
    do_line(y, 100);
    clear_table();
    do_line(10'd0, 600);
    do_line(10'd0, 600);

    // Reset while a command is pending
    for (int i = 0; i < 20; i++) begin
      t_y[i*3] = 10'd0; t_h[i*3] = 8'd50;
    end
    do_line(10'd5, 600);
    ready_mode = 3;
    mon_en = 1'b0;
    line = 1'b1;
    line_y = 10'd0;
    @(negedge clk);
    line = 1'b0;
    @(negedge clk);
    check("valid_pre_rst", 64'(spr_valid), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(spr_valid), 64'd0);
    check("async_rst_done", 64'(spr_done), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_cmd_after_rst", 64'(spr_valid), 64'd0);
    end
    scan_q.delete();
    drain_q.delete();
    got_q.delete();
    scan_ovf = 1'b0;
    scan_late_m = 1'b0;
    ready_mode = 1;
    mon_en = 1'b1;

    y = 10'($urandom);
    rand_table(y, 8);
    do_line(y, 600);
    clear_table();
    do_line(10'd0, 600);
    check_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
